// File: rtl/spis_avmm_pkg.sv
// Shared types and constants for the SPI-slave Avalon-MM burst master.
// The optional watchdog is enabled with SPIS_AVMM_TIMEOUT_EN.
package spis_avmm_pkg;

  localparam int unsigned BEAT_W = 9;
  localparam logic [15:0] WR_BUF_BASE_C = 16'h0200;
  localparam logic [15:0] RD_BUF_BASE_C = 16'h1000;
  localparam int unsigned TIMEOUT_CYCLES_C = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StWrPop,
    StWrReq,
    StRdReq,
    StRdWait,
    StDone,
    StWaitClr
  } state_e;

endpackage

// File: rtl/spis_avmm_wdog.sv
// Stall watchdog: counts consecutive active cycles without progress and
// raises a sticky error when the limit is reached (used with SPIS_AVMM_TIMEOUT_EN).
module spis_avmm_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic progress,
  output logic expire,
  output logic err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic          err_q;
  logic          stall;

  assign stall  = active && !progress;
  // Fires on the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign expire = stall && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!stall || expire) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spis_avmm_master.sv
// Avalon-MM burst master: drains the write buffer into single-beat writes or fills the
// read buffer from reads. Optional watchdog enabled by SPIS_AVMM_TIMEOUT_EN.
module spis_avmm_master
  import spis_avmm_pkg::*;
#(
  parameter logic [15:0] WR_BUF_BASE    = WR_BUF_BASE_C,
  parameter logic [15:0] RD_BUF_BASE    = RD_BUF_BASE_C,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_C
) (
  input  logic        s_avmm_clk,
  input  logic        s_avmm_rst,
  input  logic        avmm_transvld,
  input  logic        avmm_rdnwr,
  input  logic [16:0] avmm_offset,
  input  logic [1:0]  avmm_sel,
  input  logic [7:0]  avmm_brstlen,
  input  logic [31:0] reg2avb_wdata,
  output logic        avb2reg_read,
  output logic        avb2reg_read_pulse,
  output logic        avb2reg_write,
  output logic [15:0] avb2reg_addr,
  output logic [31:0] avb2reg_rdata,
  output logic        avmmtransvld_up,
  output logic [16:0] m_avmm_address,
  output logic [1:0]  m_avmm_sel,
  output logic        m_avmm_write,
  output logic        m_avmm_read,
  output logic [31:0] m_avmm_writedata,
  input  logic        m_avmm_waitrequest,
  input  logic [31:0] m_avmm_readdata,
  input  logic        m_avmm_readdatavalid,
  output logic        avmm_busy,
  output logic        avmm_timeout_err
);

  state_e              state_q, state_d;
  logic [16:0]         addr_q, addr_d;
  logic [1:0]          sel_q, sel_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [15:0]         buf_addr_q, buf_addr_d;
  logic                pop_q, pop_d;
  logic                push_q, push_d;
  logic                up_q, up_d;
  logic                mwrite_q, mwrite_d;
  logic                mread_q, mread_d;
  logic                busy_q;
  logic                rd_beat;
  logic                expire;

  // A read beat completes when data returns, either with the accept or afterwards.
  assign rd_beat = m_avmm_readdatavalid &&
                   ((state_q == StRdReq && !m_avmm_waitrequest) || state_q == StRdWait);

`ifdef SPIS_AVMM_TIMEOUT_EN
  logic wd_active;
  logic wd_progress;

  assign wd_active   = (state_q == StWrReq) || (state_q == StRdReq) || (state_q == StRdWait);
  assign wd_progress = ((state_q == StWrReq || state_q == StRdReq) && !m_avmm_waitrequest) ||
                       (state_q == StRdWait && m_avmm_readdatavalid);

  spis_avmm_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (s_avmm_clk),
    .rst     (s_avmm_rst),
    .active  (wd_active),
    .progress(wd_progress),
    .expire  (expire),
    .err     (avmm_timeout_err)
  );
`else
  logic unused_timeout;
  assign unused_timeout   = ^TIMEOUT_CYCLES;
  assign expire           = 1'b0;
  assign avmm_timeout_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    beats_d    = beats_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    buf_addr_d = buf_addr_q;
    pop_d      = 1'b0;
    push_d     = 1'b0;
    up_d       = 1'b0;
    mwrite_d   = 1'b0;
    mread_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (avmm_transvld) begin
          addr_d  = avmm_offset;
          sel_d   = avmm_sel;
          beats_d = {1'b0, avmm_brstlen} + BEAT_W'(1);
          if (avmm_rdnwr) begin
            state_d = StRdReq;
            mread_d = 1'b1;
          end else begin
            state_d    = StWrPop;
            pop_d      = 1'b1;
            buf_addr_d = WR_BUF_BASE;
          end
        end
      end
      StWrPop: begin
        wdata_d  = reg2avb_wdata;
        mwrite_d = 1'b1;
        state_d  = StWrReq;
      end
      StWrReq: begin
        if (!m_avmm_waitrequest) begin
          addr_d  = addr_q + 17'd4;
          beats_d = beats_q - BEAT_W'(1);
          if (beats_q > BEAT_W'(1)) begin
            state_d    = StWrPop;
            pop_d      = 1'b1;
            buf_addr_d = WR_BUF_BASE;
          end else begin
            state_d = StDone;
            up_d    = 1'b1;
          end
        end else begin
          mwrite_d = 1'b1;
        end
      end
      StRdReq: begin
        if (m_avmm_waitrequest) begin
          mread_d = 1'b1;
        end else if (!m_avmm_readdatavalid) begin
          state_d = StRdWait;
        end
      end
      StRdWait: ;
      // Writes arrive with up already set; reads need the extra cycle after the last push.
      StDone: begin
        if (up_q) begin
          state_d = StWaitClr;
        end else begin
          up_d = 1'b1;
        end
      end
      StWaitClr: begin
        if (!avmm_transvld) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rd_beat) begin
      rdata_d    = m_avmm_readdata;
      push_d     = 1'b1;
      buf_addr_d = RD_BUF_BASE;
      addr_d     = addr_q + 17'd4;
      beats_d    = beats_q - BEAT_W'(1);
      if (beats_q > BEAT_W'(1)) begin
        state_d = StRdReq;
        mread_d = 1'b1;
      end else begin
        state_d = StDone;
      end
    end

    if (expire) begin
      state_d  = StDone;
      mread_d  = 1'b0;
      mwrite_d = 1'b0;
      up_d     = 1'b1;
    end
  end

  always_ff @(posedge s_avmm_clk or posedge s_avmm_rst) begin
    if (s_avmm_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      sel_q      <= '0;
      beats_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      buf_addr_q <= '0;
      pop_q      <= 1'b0;
      push_q     <= 1'b0;
      up_q       <= 1'b0;
      mwrite_q   <= 1'b0;
      mread_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      beats_q    <= beats_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      buf_addr_q <= buf_addr_d;
      pop_q      <= pop_d;
      push_q     <= push_d;
      up_q       <= up_d;
      mwrite_q   <= mwrite_d;
      mread_q    <= mread_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign avb2reg_read       = pop_q;
  assign avb2reg_read_pulse = pop_q;
  assign avb2reg_write      = push_q;
  assign avb2reg_addr       = buf_addr_q;
  assign avb2reg_rdata      = rdata_q;
  assign avmmtransvld_up    = up_q;
  assign m_avmm_address     = addr_q;
  assign m_avmm_sel         = sel_q;
  assign m_avmm_write       = mwrite_q;
  assign m_avmm_read        = mread_q;
  assign m_avmm_writedata   = wdata_q;
  assign avmm_busy          = busy_q;

endmodule

// File: tb/tb_spis_avmm_master.sv
// Directed bench for spis_avmm_master with a write-buffer source and a read-latency slave.
// The timeout scenario is built in when SPIS_AVMM_TIMEOUT_EN is defined.
module tb_spis_avmm_master;

  logic        s_avmm_clk = 1'b0;
  logic        s_avmm_rst = 1'b1;
  logic        avmm_transvld = 1'b0;
  logic        avmm_rdnwr = 1'b0;
  logic [16:0] avmm_offset = '0;
  logic [1:0]  avmm_sel = '0;
  logic [7:0]  avmm_brstlen = '0;
  logic [31:0] reg2avb_wdata = '0;
  logic        avb2reg_read;
  logic        avb2reg_read_pulse;
  logic        avb2reg_write;
  logic [15:0] avb2reg_addr;
  logic [31:0] avb2reg_rdata;
  logic        avmmtransvld_up;
  logic [16:0] m_avmm_address;
  logic [1:0]  m_avmm_sel;
  logic        m_avmm_write;
  logic        m_avmm_read;
  logic [31:0] m_avmm_writedata;
  logic        m_avmm_waitrequest = 1'b0;
  logic [31:0] m_avmm_readdata = '0;
  logic        m_avmm_readdatavalid = 1'b0;
  logic        avmm_busy;
  logic        avmm_timeout_err;

  spis_avmm_master dut (
    .s_avmm_clk          (s_avmm_clk),
    .s_avmm_rst          (s_avmm_rst),
    .avmm_transvld       (avmm_transvld),
    .avmm_rdnwr          (avmm_rdnwr),
    .avmm_offset         (avmm_offset),
    .avmm_sel            (avmm_sel),
    .avmm_brstlen        (avmm_brstlen),
    .reg2avb_wdata       (reg2avb_wdata),
    .avb2reg_read        (avb2reg_read),
    .avb2reg_read_pulse  (avb2reg_read_pulse),
    .avb2reg_write       (avb2reg_write),
    .avb2reg_addr        (avb2reg_addr),
    .avb2reg_rdata       (avb2reg_rdata),
    .avmmtransvld_up     (avmmtransvld_up),
    .m_avmm_address      (m_avmm_address),
    .m_avmm_sel          (m_avmm_sel),
    .m_avmm_write        (m_avmm_write),
    .m_avmm_read         (m_avmm_read),
    .m_avmm_writedata    (m_avmm_writedata),
    .m_avmm_waitrequest  (m_avmm_waitrequest),
    .m_avmm_readdata     (m_avmm_readdata),
    .m_avmm_readdatavalid(m_avmm_readdatavalid),
    .avmm_busy           (avmm_busy),
    .avmm_timeout_err    (avmm_timeout_err)
  );

  always #5 s_avmm_clk = ~s_avmm_clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  int cyc = 0;
  int pop_cnt = 0, wr_n = 0, rd_n = 0, push_n = 0, up_cnt = 0;
  int pend = 0, rd_lat = 1, rd_resp_n = 0;
  int first_pop_cyc = 0, last_wr_cyc = 0, rdv_cyc = 0, push_cyc = 0, up_cyc = 0;
  logic [31:0] rd_base = '0;
  logic [16:0] wr_addr [16];
  logic [31:0] wr_data [16];
  logic [1:0]  wr_sel  [16];
  logic [16:0] rd_addr [16];
  logic [31:0] push_data [16];
  logic [15:0] push_addr [16];

  // Bus monitor: records handshakes at the active edge.
  always @(posedge s_avmm_clk) begin
    cyc++;
    if (!s_avmm_rst) begin
      if (avb2reg_read_pulse) begin
        if (pop_cnt == 0) first_pop_cyc = cyc;
        pop_cnt++;
      end
      if (m_avmm_write && !m_avmm_waitrequest) begin
        wr_addr[wr_n % 16] = m_avmm_address;
        wr_data[wr_n % 16] = m_avmm_writedata;
        wr_sel[wr_n % 16]  = m_avmm_sel;
        wr_n++;
        last_wr_cyc = cyc;
      end
      if (m_avmm_read && !m_avmm_waitrequest) begin
        rd_addr[rd_n % 16] = m_avmm_address;
        rd_n++;
        pend = rd_lat;
      end
      if (m_avmm_readdatavalid) rdv_cyc = cyc;
      if (avb2reg_write) begin
        push_data[push_n % 16] = avb2reg_rdata;
        push_addr[push_n % 16] = avb2reg_addr;
        push_n++;
        push_cyc = cyc;
      end
      if (avmmtransvld_up) begin
        up_cnt++;
        up_cyc = cyc;
      end
    end
  end

  // Write-buffer source (word = 0xA0 + pops so far) and read slave with fixed latency.
  always @(negedge s_avmm_clk) begin
    reg2avb_wdata = 32'hA0 + 32'(pop_cnt);
    m_avmm_readdatavalid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        m_avmm_readdatavalid = 1'b1;
        m_avmm_readdata = rd_base + 32'(rd_resp_n);
        rd_resp_n++;
      end
    end
  end

  task automatic clr;
    pop_cnt = 0; wr_n = 0; rd_n = 0; push_n = 0; up_cnt = 0; rd_resp_n = 0;
  endtask

  task automatic start_cmd(input logic rdnwr, input logic [16:0] off, input logic [1:0] sel,
                           input logic [7:0] len);
    avmm_rdnwr = rdnwr; avmm_offset = off; avmm_sel = sel; avmm_brstlen = len;
    avmm_transvld = 1'b1;
    @(negedge s_avmm_clk);
  endtask

  task automatic wait_up(input int budget, output bit ok);
    int start;
    start = up_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge s_avmm_clk);
      if (up_cnt != start) ok = 1'b1;
    end
  endtask

  task automatic finish_cmd;
    avmm_transvld = 1'b0;
    repeat (2) @(negedge s_avmm_clk);
  endtask

  task automatic test_reset;
    s_avmm_rst = 1'b1;
    repeat (2) @(negedge s_avmm_clk);
    total_cnt++;
    if ({m_avmm_write, m_avmm_read, avb2reg_read, avb2reg_read_pulse, avb2reg_write,
         avmmtransvld_up, avmm_busy, avmm_timeout_err} !== 8'b0)
      $display("FAIL reset_ctrl: got %b want 00000000", {m_avmm_write, m_avmm_read,
               avb2reg_read, avb2reg_read_pulse, avb2reg_write, avmmtransvld_up, avmm_busy,
               avmm_timeout_err});
    else pass_cnt++;
    total_cnt++;
    if ({m_avmm_address, m_avmm_sel, avb2reg_addr} !== 35'b0)
      $display("FAIL reset_addr: got %h/%h/%h want 0", m_avmm_address, m_avmm_sel, avb2reg_addr);
    else pass_cnt++;
    total_cnt++;
    if ({m_avmm_writedata, avb2reg_rdata} !== 64'b0)
      $display("FAIL reset_data: got %h/%h want 0", m_avmm_writedata, avb2reg_rdata);
    else pass_cnt++;
    s_avmm_rst = 1'b0;
    repeat (2) @(negedge s_avmm_clk);
    total_cnt++;
    if (avmm_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", avmm_busy);
    else pass_cnt++;
  endtask

  task automatic test_write_burst;
    bit ok;
    clr();
    m_avmm_waitrequest = 1'b0;
    start_cmd(1'b0, 17'h00100, 2'd2, 8'd3);
    total_cnt++;
    if ({avb2reg_read_pulse, avb2reg_read, avmm_busy} !== 3'b111 || avb2reg_addr !== 16'h0200)
      $display("FAIL wr_first_pop: got pulse=%b rd=%b busy=%b addr=%h want 1 1 1 0200",
               avb2reg_read_pulse, avb2reg_read, avmm_busy, avb2reg_addr);
    else pass_cnt++;
    @(negedge s_avmm_clk);
    total_cnt++;
    if (avb2reg_read_pulse !== 1'b0 || m_avmm_write !== 1'b1 || m_avmm_writedata !== 32'hA0 ||
        m_avmm_address !== 17'h00100 || m_avmm_sel !== 2'd2)
      $display("FAIL wr_first_req: got pulse=%b wr=%b data=%h addr=%h sel=%0d want 0 1 a0 100 2",
               avb2reg_read_pulse, m_avmm_write, m_avmm_writedata, m_avmm_address, m_avmm_sel);
    else pass_cnt++;
    wait_up(40, ok);
    total_cnt++;
    if (!ok) $display("FAIL wr_up_timeout: got no up want up");
    else pass_cnt++;
    total_cnt++;
    if (pop_cnt != 4 || wr_n != 4)
      $display("FAIL wr_counts: got pops=%0d writes=%0d want 4 4", pop_cnt, wr_n);
    else pass_cnt++;
    for (int i = 0; i < wr_n && i < 4; i++) begin
      total_cnt++;
      if (wr_addr[i] !== 17'h00100 + 17'(4 * i) || wr_data[i] !== 32'hA0 + 32'(i) ||
          wr_sel[i] !== 2'd2)
        $display("FAIL wr_beat%0d: got addr=%h data=%h sel=%0d want %h %h 2", i, wr_addr[i],
                 wr_data[i], wr_sel[i], 17'h00100 + 17'(4 * i), 32'hA0 + 32'(i));
      else pass_cnt++;
    end
    total_cnt++;
    if (last_wr_cyc - first_pop_cyc != 7 || up_cyc - last_wr_cyc != 1)
      $display("FAIL wr_timing: got span=%0d up_lag=%0d want 7 1", last_wr_cyc - first_pop_cyc,
               up_cyc - last_wr_cyc);
    else pass_cnt++;
    finish_cmd();
    total_cnt++;
    if (avmm_busy !== 1'b0 || up_cnt != 1)
      $display("FAIL wr_end: got busy=%b ups=%0d want 0 1", avmm_busy, up_cnt);
    else pass_cnt++;
  endtask

  task automatic test_read_single;
    bit ok;
    clr();
    rd_base = 32'hCAFEF00D;
    rd_lat = 5;
    start_cmd(1'b1, 17'h1FFFC, 2'd1, 8'd0);
    total_cnt++;
    if (m_avmm_read !== 1'b1 || m_avmm_address !== 17'h1FFFC)
      $display("FAIL rd_first_req: got rd=%b addr=%h want 1 1fffc", m_avmm_read, m_avmm_address);
    else pass_cnt++;
    wait_up(40, ok);
    total_cnt++;
    if (!ok) $display("FAIL rd_up_timeout: got no up want up");
    else pass_cnt++;
    total_cnt++;
    if (rd_n != 1 || push_n != 1 || push_data[0] !== 32'hCAFEF00D || push_addr[0] !== 16'h1000)
      $display("FAIL rd_push: got reads=%0d pushes=%0d data=%h addr=%h want 1 1 cafef00d 1000",
               rd_n, push_n, push_data[0], push_addr[0]);
    else pass_cnt++;
    total_cnt++;
    if (push_cyc - rdv_cyc != 1 || up_cyc - rdv_cyc != 2)
      $display("FAIL rd_timing: got push_lag=%0d up_lag=%0d want 1 2", push_cyc - rdv_cyc,
               up_cyc - rdv_cyc);
    else pass_cnt++;
    finish_cmd();
  endtask

  task automatic test_read_wrap;
    bit ok;
    clr();
    rd_base = 32'h11110000;
    rd_lat = 1;
    start_cmd(1'b1, 17'h1FFFC, 2'd3, 8'd1);
    wait_up(40, ok);
    total_cnt++;
    if (!ok) $display("FAIL wrap_up_timeout: got no up want up");
    else pass_cnt++;
    total_cnt++;
    if (rd_n != 2 || rd_addr[0] !== 17'h1FFFC || rd_addr[1] !== 17'h00000)
      $display("FAIL wrap_addr: got n=%0d a0=%h a1=%h want 2 1fffc 00000", rd_n, rd_addr[0],
               rd_addr[1]);
    else pass_cnt++;
    total_cnt++;
    if (push_n != 2 || push_data[0] !== 32'h11110000 || push_data[1] !== 32'h11110001)
      $display("FAIL wrap_push: got n=%0d d0=%h d1=%h want 2 11110000 11110001", push_n,
               push_data[0], push_data[1]);
    else pass_cnt++;
    finish_cmd();
  endtask

  task automatic test_write_waitreq;
    bit ok;
    clr();
    m_avmm_waitrequest = 1'b0;
    start_cmd(1'b0, 17'h00040, 2'd1, 8'd1);
    m_avmm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge s_avmm_clk);
      total_cnt++;
      if (m_avmm_write !== 1'b1 || m_avmm_writedata !== 32'hA0 ||
          m_avmm_address !== 17'h00040 || avb2reg_read_pulse !== 1'b0)
        $display("FAIL stall_hold%0d: got wr=%b data=%h addr=%h pop=%b want 1 a0 40 0", i,
                 m_avmm_write, m_avmm_writedata, m_avmm_address, avb2reg_read_pulse);
      else pass_cnt++;
    end
    m_avmm_waitrequest = 1'b0;
    wait_up(20, ok);
    total_cnt++;
    if (!ok) $display("FAIL stall_up_timeout: got no up want up");
    else pass_cnt++;
    total_cnt++;
    if (pop_cnt != 2 || wr_n != 2 || wr_data[0] !== 32'hA0 || wr_data[1] !== 32'hA1 ||
        wr_addr[1] !== 17'h00044 || wr_sel[1] !== 2'd1 || up_cnt != 1)
      $display("FAIL stall_result: got pops=%0d wr=%0d d0=%h d1=%h a1=%h s=%0d up=%0d want 2 2 a0 a1 44 1 1",
               pop_cnt, wr_n, wr_data[0], wr_data[1], wr_addr[1], wr_sel[1], up_cnt);
    else pass_cnt++;
    finish_cmd();
  endtask

  task automatic test_transvld_hold;
    bit ok;
    clr();
    start_cmd(1'b0, 17'h00008, 2'd0, 8'd0);
    wait_up(20, ok);
    total_cnt++;
    if (!ok) $display("FAIL hold_up_timeout: got no up want up");
    else pass_cnt++;
    repeat (20) @(negedge s_avmm_clk);
    total_cnt++;
    if (up_cnt != 1 || pop_cnt != 1 || avmm_busy !== 1'b1)
      $display("FAIL hold_no_retrigger: got ups=%0d pops=%0d busy=%b want 1 1 1", up_cnt, pop_cnt,
               avmm_busy);
    else pass_cnt++;
    avmm_transvld = 1'b0;
    @(negedge s_avmm_clk);
    avmm_transvld = 1'b1;
    @(negedge s_avmm_clk);
    total_cnt++;
    if (avb2reg_read_pulse !== 1'b1)
      $display("FAIL hold_rearm: got pop=%b want 1", avb2reg_read_pulse);
    else pass_cnt++;
    wait_up(20, ok);
    total_cnt++;
    if (!ok || up_cnt != 2) $display("FAIL hold_second_up: got ups=%0d want 2", up_cnt);
    else pass_cnt++;
    finish_cmd();
  endtask

`ifdef SPIS_AVMM_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    clr();
    m_avmm_waitrequest = 1'b1;
    start_cmd(1'b1, 17'h00000, 2'd0, 8'd0);
    wait_up(1100, ok);
    total_cnt++;
    if (!ok) $display("FAIL to_up: got no up want up");
    else pass_cnt++;
    total_cnt++;
    if (avmm_timeout_err !== 1'b1 || m_avmm_read !== 1'b0 || push_n != 0)
      $display("FAIL to_state: got err=%b rd=%b pushes=%0d want 1 0 0", avmm_timeout_err,
               m_avmm_read, push_n);
    else pass_cnt++;
    m_avmm_waitrequest = 1'b0;
    finish_cmd();
    total_cnt++;
    if (avmm_timeout_err !== 1'b1) $display("FAIL to_sticky: got err=%b want 1", avmm_timeout_err);
    else pass_cnt++;
  endtask
`else
  task automatic test_no_timeout;
    bit ok;
    clr();
    rd_base = 32'h0BADBEEF;
    rd_lat = 1;
    m_avmm_waitrequest = 1'b1;
    start_cmd(1'b1, 17'h00010, 2'd0, 8'd0);
    repeat (50) @(negedge s_avmm_clk);
    total_cnt++;
    if (avmm_timeout_err !== 1'b0 || m_avmm_read !== 1'b1 || up_cnt != 0)
      $display("FAIL nto_wait: got err=%b rd=%b ups=%0d want 0 1 0", avmm_timeout_err,
               m_avmm_read, up_cnt);
    else pass_cnt++;
    m_avmm_waitrequest = 1'b0;
    wait_up(20, ok);
    total_cnt++;
    if (!ok || push_n != 1 || push_data[0] !== 32'h0BADBEEF)
      $display("FAIL nto_finish: got up=%b pushes=%0d data=%h want 1 1 0badbeef", ok, push_n,
               push_data[0]);
    else pass_cnt++;
    finish_cmd();
  endtask
`endif

  task automatic test_reset_mid_read;
    bit ok;
    clr();
    rd_base = 32'h55AA0000;
    rd_lat = 2;
    m_avmm_waitrequest = 1'b0;
    start_cmd(1'b1, 17'h00020, 2'd2, 8'd3);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge s_avmm_clk);
      if (push_n >= 1) ok = 1'b1;
    end
    total_cnt++;
    if (!ok) $display("FAIL mid_first_push: got no push want push");
    else pass_cnt++;
    s_avmm_rst = 1'b1;
    avmm_transvld = 1'b0;
    @(negedge s_avmm_clk);
    total_cnt++;
    if ({m_avmm_write, m_avmm_read, avb2reg_read_pulse, avb2reg_write, avmmtransvld_up,
         avmm_busy} !== 6'b0 || m_avmm_address !== 17'h0 || avb2reg_addr !== 16'h0 ||
        avb2reg_rdata !== 32'h0 || m_avmm_sel !== 2'd0)
      $display("FAIL mid_reset_outs: got ctl=%b addr=%h badr=%h rdata=%h sel=%0d want 0",
               {m_avmm_write, m_avmm_read, avb2reg_read_pulse, avb2reg_write, avmmtransvld_up,
                avmm_busy}, m_avmm_address, avb2reg_addr, avb2reg_rdata, m_avmm_sel);
    else pass_cnt++;
    repeat (3) @(negedge s_avmm_clk);
    s_avmm_rst = 1'b0;
    repeat (10) @(negedge s_avmm_clk);
    total_cnt++;
    if (up_cnt != 0 || push_n != 1 || avmm_busy !== 1'b0)
      $display("FAIL mid_after: got ups=%0d pushes=%0d busy=%b want 0 1 0", up_cnt, push_n,
               avmm_busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_single();
    test_read_wrap();
    test_write_waitreq();
    test_transvld_hold();
`ifdef SPIS_AVMM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
